// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per execution unit, round-robin
// selection of one full slot per cycle onto a registered broadcast bus.
module cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_val,
    input  logic [NUM_REQ*DATA_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_active,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_val,
    output logic [DATA_W-1:0]         cdb_addr,
    output logic                      busy_out
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] r_full;
    logic [TAG_W-1:0]   r_tag  [NUM_REQ];
    logic [DATA_W-1:0]  r_val  [NUM_REQ];
    logic [DATA_W-1:0]  r_addr [NUM_REQ];
    logic [PTR_W-1:0]   r_ptr;
    logic               r_cdb_active;
    logic [TAG_W-1:0]   r_cdb_tag;
    logic [DATA_W-1:0]  r_cdb_val;
    logic [DATA_W-1:0]  r_cdb_addr;

    logic               w_advance;
    logic               w_any_grant;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_accept;
    logic [NUM_REQ-1:0] w_full_next;
    logic [PTR_W:0]     w_pos;
    logic [PTR_W-1:0]   w_win_idx;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [TAG_W-1:0]   w_win_tag;
    logic [DATA_W-1:0]  w_win_val;
    logic [DATA_W-1:0]  w_win_addr;

    assign w_advance = rst_in & rdy_in & ~flush_in;
    assign req_ready = {NUM_REQ{w_advance}} & (~r_full | w_grant);
    assign w_accept  = req_valid & req_ready;
    assign busy_out  = |r_full;

    // Round-robin search: visit ptr, ptr+1, ... wrapping at NUM_REQ.
    // NOTE: blocking assignments are correct here; w_pos and w_any_grant are
    // scratch values rewritten every iteration, and all get a default first
    // so no latch is inferred.
    always_comb begin
        w_grant     = '0;
        w_any_grant = 1'b0;
        w_pos       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_pos >= (PTR_W+1)'(NUM_REQ)) begin
                w_pos = w_pos - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_any_grant && r_full[w_pos[PTR_W-1:0]]) begin
                w_grant[w_pos[PTR_W-1:0]] = 1'b1;
                w_any_grant               = 1'b1;
            end
        end
    end

    always_comb begin
        w_win_idx  = '0;
        w_win_tag  = '0;
        w_win_val  = '0;
        w_win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_win_idx  = PTR_W'(i);
                w_win_tag  = r_tag[i];
                w_win_val  = r_val[i];
                w_win_addr = r_addr[i];
            end
        end
    end

    assign w_ptr_next = (w_win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;

    // Tag 0 means "no result": such an accept leaves the slot empty.
    always_comb begin
        w_full_next = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_full_next[i] = (r_full[i] & ~w_grant[i]) |
                             (w_accept[i] & (req_tag[i*TAG_W +: TAG_W] != '0));
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_full       <= '0;
            r_ptr        <= '0;
            r_cdb_active <= 1'b0;
            r_cdb_tag    <= '0;
            r_cdb_val    <= '0;
            r_cdb_addr   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_full       <= '0;
                r_cdb_active <= 1'b0;
                r_cdb_tag    <= '0;
                r_cdb_val    <= '0;
                r_cdb_addr   <= '0;
            end else begin
                r_full       <= w_full_next;
                r_cdb_active <= w_any_grant;
                r_cdb_tag    <= w_win_tag;
                r_cdb_val    <= w_win_val;
                r_cdb_addr   <= w_win_addr;
                if (w_any_grant) begin
                    r_ptr <= w_ptr_next;
                end
            end
        end
    end

    // NOTE: slot payload has no reset; it is only ever read while its full
    // bit is set, and full is cleared by reset.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept[i]) begin
                r_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
                r_val[i]  <= req_val[i*DATA_W +: DATA_W];
                r_addr[i] <= req_addr[i*DATA_W +: DATA_W];
            end
        end
    end

    assign cdb_active = r_cdb_active;
    assign cdb_tag    = r_cdb_tag;
    assign cdb_val    = r_cdb_val;
    assign cdb_addr   = r_cdb_addr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, contention, fairness,
// pause / tag-0 handling and flush, each with hand-computed expectations.
module tb_cdb_arbiter;
    localparam int NUM_REQ = 3;
    localparam int TAG_W   = 4;
    localparam int DATA_W  = 32;

    logic                      clk_in;
    logic                      rst_in;
    logic                      rdy_in;
    logic                      flush_in;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_val;
    logic [NUM_REQ*DATA_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cdb_active;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_val;
    logic [DATA_W-1:0]         cdb_addr;
    logic                      busy_out;

    int n_pass  = 0;
    int n_total = 0;

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush_in  (flush_in),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_val   (req_val),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .cdb_active(cdb_active),
        .cdb_tag   (cdb_tag),
        .cdb_val   (cdb_val),
        .cdb_addr  (cdb_addr),
        .busy_out  (busy_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Outputs settle 2 time units after the edge; new inputs are driven then.
    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic set_req(input int i, input logic [TAG_W-1:0] tag,
                           input logic [DATA_W-1:0] val, input logic [DATA_W-1:0] addr);
        req_tag[i*TAG_W +: TAG_W]    = tag;
        req_val[i*DATA_W +: DATA_W]  = val;
        req_addr[i*DATA_W +: DATA_W] = addr;
        req_valid[i]                 = 1'b1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        flush_in  = 1'b0;
        rdy_in    = 1'b1;
        rst_in    = 1'b0;
        tick();
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_in    = 1'b0;
        set_req(0, 4'd1, 32'h1, 32'h0);
        set_req(1, 4'd2, 32'h2, 32'h0);
        set_req(2, 4'd3, 32'h3, 32'h0);
        #1;
        n_total++; if (req_ready !== 3'b000) $display("FAIL reset_ready_early got=%b exp=000", req_ready); else n_pass++;
        tick();
        tick();
        n_total++; if (req_ready !== 3'b000) $display("FAIL reset_ready got=%b exp=000", req_ready); else n_pass++;
        n_total++; if (cdb_active !== 1'b0) $display("FAIL reset_active got=%b exp=0", cdb_active); else n_pass++;
        n_total++; if (cdb_tag !== 4'd0) $display("FAIL reset_tag got=%0d exp=0", cdb_tag); else n_pass++;
        n_total++; if (busy_out !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_out); else n_pass++;
        rst_in = 1'b1;
        #1;
        n_total++; if (req_ready !== 3'b111) $display("FAIL release_ready got=%b exp=111", req_ready); else n_pass++;
        req_valid = '0;
        tick();
        n_total++; if (busy_out !== 1'b0) $display("FAIL release_busy got=%b exp=0", busy_out); else n_pass++;
    endtask

    task automatic test_single();
        set_req(0, 4'd5, 32'h1234, 32'h8000_0010);
        tick();
        req_valid = '0;
        n_total++; if (busy_out !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy_out); else n_pass++;
        n_total++; if (cdb_active !== 1'b0) $display("FAIL single_k1_active got=%b exp=0", cdb_active); else n_pass++;
        tick();
        n_total++; if (cdb_active !== 1'b1) $display("FAIL single_active got=%b exp=1", cdb_active); else n_pass++;
        n_total++; if (cdb_tag !== 4'd5) $display("FAIL single_tag got=%0d exp=5", cdb_tag); else n_pass++;
        n_total++; if (cdb_val !== 32'h1234) $display("FAIL single_val got=%h exp=1234", cdb_val); else n_pass++;
        n_total++; if (cdb_addr !== 32'h8000_0010) $display("FAIL single_addr got=%h exp=80000010", cdb_addr); else n_pass++;
        tick();
        n_total++; if (cdb_active !== 1'b0) $display("FAIL single_k3_active got=%b exp=0", cdb_active); else n_pass++;
        n_total++; if (cdb_tag !== 4'd0) $display("FAIL single_k3_tag got=%0d exp=0", cdb_tag); else n_pass++;
    endtask

    task automatic test_contention();
        logic [TAG_W-1:0] exp_tag [3];
        logic             exp_busy [3];
        exp_tag[0] = 4'd1; exp_tag[1] = 4'd2; exp_tag[2] = 4'd3;
        exp_busy[0] = 1'b1; exp_busy[1] = 1'b1; exp_busy[2] = 1'b0;
        do_reset();
        set_req(0, 4'd1, 32'h111, 32'h0);
        set_req(1, 4'd2, 32'h222, 32'h0);
        set_req(2, 4'd3, 32'h333, 32'h0);
        tick();
        req_valid = '0;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_total++; if (cdb_active !== 1'b1 || cdb_tag !== exp_tag[j])
                $display("FAIL contention_tag%0d got=%b/%0d exp=1/%0d", j, cdb_active, cdb_tag, exp_tag[j]); else n_pass++;
            n_total++; if (busy_out !== exp_busy[j])
                $display("FAIL contention_busy%0d got=%b exp=%b", j, busy_out, exp_busy[j]); else n_pass++;
        end
        n_total++; if (cdb_val !== 32'h333) $display("FAIL contention_val got=%h exp=333", cdb_val); else n_pass++;
        tick();
        n_total++; if (cdb_active !== 1'b0) $display("FAIL contention_idle got=%b exp=0", cdb_active); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [TAG_W-1:0] exp;
        do_reset();
        set_req(0, 4'd4, 32'h44, 32'h0);
        set_req(1, 4'd7, 32'h77, 32'h0);
        tick();
        for (int j = 0; j < 6; j++) begin
            tick();
            exp = (j % 2 == 0) ? 4'd4 : 4'd7;
            n_total++; if (cdb_active !== 1'b1 || cdb_tag !== exp)
                $display("FAIL rr_tag%0d got=%b/%0d exp=1/%0d", j, cdb_active, cdb_tag, exp); else n_pass++;
        end
        req_valid = '0;
        tick();
        tick();
        n_total++; if (busy_out !== 1'b0) $display("FAIL rr_drain_busy got=%b exp=0", busy_out); else n_pass++;
        tick();
        n_total++; if (cdb_active !== 1'b0) $display("FAIL rr_drain_active got=%b exp=0", cdb_active); else n_pass++;
    endtask

    task automatic test_pause_tag0();
        do_reset();
        set_req(0, 4'd9, 32'h99, 32'h0);
        set_req(1, 4'd10, 32'hAA, 32'h0);
        tick();
        req_valid = '0;
        tick();
        n_total++; if (cdb_tag !== 4'd9) $display("FAIL pause_pre_tag got=%0d exp=9", cdb_tag); else n_pass++;
        rdy_in   = 1'b0;
        flush_in = 1'b1;
        set_req(0, 4'd11, 32'hBB, 32'h0);
        #1;
        n_total++; if (req_ready !== 3'b000) $display("FAIL pause_ready got=%b exp=000", req_ready); else n_pass++;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_total++; if (cdb_active !== 1'b1 || cdb_tag !== 4'd9 || cdb_val !== 32'h99)
                $display("FAIL pause_hold%0d got=%b/%0d/%h exp=1/9/99", j, cdb_active, cdb_tag, cdb_val); else n_pass++;
            n_total++; if (busy_out !== 1'b1) $display("FAIL pause_busy%0d got=%b exp=1", j, busy_out); else n_pass++;
        end
        rdy_in    = 1'b1;
        flush_in  = 1'b0;
        req_valid = '0;
        tick();
        n_total++; if (cdb_active !== 1'b1 || cdb_tag !== 4'd10)
            $display("FAIL pause_resume got=%b/%0d exp=1/10", cdb_active, cdb_tag); else n_pass++;
        n_total++; if (busy_out !== 1'b0) $display("FAIL pause_no_accept got=%b exp=0", busy_out); else n_pass++;
        tick();
        n_total++; if (cdb_active !== 1'b0) $display("FAIL pause_idle got=%b exp=0", cdb_active); else n_pass++;
        set_req(2, 4'd0, 32'hDEAD, 32'h0);
        #1;
        n_total++; if (req_ready[2] !== 1'b1) $display("FAIL tag0_ready got=%b exp=1", req_ready[2]); else n_pass++;
        tick();
        req_valid = '0;
        n_total++; if (busy_out !== 1'b0) $display("FAIL tag0_busy got=%b exp=0", busy_out); else n_pass++;
        tick();
        n_total++; if (cdb_active !== 1'b0) $display("FAIL tag0_bcast1 got=%b exp=0", cdb_active); else n_pass++;
        tick();
        n_total++; if (cdb_active !== 1'b0) $display("FAIL tag0_bcast2 got=%b exp=0", cdb_active); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        set_req(1, 4'd12, 32'hC0, 32'h0);
        set_req(2, 4'd13, 32'hD0, 32'h0);
        tick();
        req_valid = '0;
        n_total++; if (busy_out !== 1'b1) $display("FAIL flush_pre_busy got=%b exp=1", busy_out); else n_pass++;
        flush_in = 1'b1;
        set_req(0, 4'd14, 32'hE0, 32'h0);
        #1;
        n_total++; if (req_ready !== 3'b000) $display("FAIL flush_ready got=%b exp=000", req_ready); else n_pass++;
        tick();
        flush_in  = 1'b0;
        req_valid = '0;
        n_total++; if (cdb_active !== 1'b0 || cdb_tag !== 4'd0)
            $display("FAIL flush_bus got=%b/%0d exp=0/0", cdb_active, cdb_tag); else n_pass++;
        n_total++; if (busy_out !== 1'b0) $display("FAIL flush_busy got=%b exp=0", busy_out); else n_pass++;
        tick();
        n_total++; if (cdb_active !== 1'b0) $display("FAIL flush_after got=%b exp=0", cdb_active); else n_pass++;
        set_req(0, 4'd15, 32'hF00D, 32'h40);
        tick();
        req_valid = '0;
        tick();
        n_total++; if (cdb_active !== 1'b1 || cdb_tag !== 4'd15 || cdb_val !== 32'hF00D)
            $display("FAIL flush_resume got=%b/%0d/%h exp=1/15/f00d", cdb_active, cdb_tag, cdb_val); else n_pass++;
    endtask

    initial begin
        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        flush_in  = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        req_val   = '0;
        req_addr  = '0;
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_pause_tag0();
        test_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
